// File: rtl/seq_div_16by8.sv
// seq_div_16by8 -- sequential restoring divider, 16-bit unsigned dividend by
// 8-bit unsigned divisor, one quotient bit per clock.
//
// Used to normalise 16-bit gradient/product terms back to 8-bit pixel range
// and to round-trip check the 8x8 multiplier. One division in flight.
//
// Ports:
//   clk          single clock, all state on the rising edge
//   rst          synchronous, active-high reset (aborts any operation)
//   in_valid     dividend/divisor valid
//   in_ready     block can accept an operation (registered, IDLE only)
//   dividend     16-bit unsigned numerator
//   divisor      8-bit unsigned denominator
//   out_valid    result valid, held until taken
//   out_ready    downstream accepts result
//   quotient     16-bit unsigned quotient (holds last result)
//   remainder    8-bit unsigned remainder (holds last result)
//   div_by_zero  result came from divisor == 0
//
// Timing (accept cycle = 0): out_valid from cycle 17 for a normal divide,
// from cycle 1 for divide-by-zero. in_ready returns the cycle after the
// output handshake, so in_ready and out_valid are never high together.
module seq_div_16by8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [15:0] q_reg;          // dividend shifts out the top, quotient bits in at the bottom
  logic [7:0]  r_reg;          // partial remainder; its 9th bit is always 0 between steps
  logic [7:0]  divisor_reg;
  logic [3:0]  count_reg;
  logic        in_ready_reg;
  logic        out_valid_reg;
  logic [15:0] quotient_reg;
  logic [7:0]  remainder_reg;
  logic        div_by_zero_reg;

  // One restoring step. The trial value can reach 2*divisor-1 (up to 509),
  // so the compare is done in 9 bits. When it fits, the difference is below
  // the divisor and therefore fits in 8 bits, so only the low byte of the
  // subtraction is needed.
  logic [8:0]  trial;
  logic        fits;
  logic [7:0]  diff;
  logic [7:0]  r_next;
  logic [15:0] q_next;

  always_comb begin
    trial  = {r_reg, q_reg[15]};
    fits   = (trial >= {1'b0, divisor_reg});
    diff   = trial[7:0] - divisor_reg;
    r_next = fits ? diff : trial[7:0];
    q_next = {q_reg[14:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      q_reg           <= 16'd0;
      r_reg           <= 8'd0;
      divisor_reg     <= 8'd0;
      count_reg       <= 4'd0;
      in_ready_reg    <= 1'b1;
      out_valid_reg   <= 1'b0;
      quotient_reg    <= 16'd0;
      remainder_reg   <= 8'd0;
      div_by_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            divisor_reg  <= divisor;
            q_reg        <= dividend;
            r_reg        <= 8'd0;
            count_reg    <= 4'd0;
            in_ready_reg <= 1'b0;
            if (divisor == 8'd0) begin
              // Skip the iterations entirely: saturated quotient, the low
              // byte of the dividend as remainder.
              quotient_reg    <= 16'hFFFF;
              remainder_reg   <= dividend[7:0];
              div_by_zero_reg <= 1'b1;
              out_valid_reg   <= 1'b1;
              state_reg       <= DONE;
            end else begin
              state_reg <= CALC;
            end
          end
        end

        CALC: begin
          q_reg     <= q_next;
          r_reg     <= r_next;
          count_reg <= count_reg + 4'd1;
          if (count_reg == 4'd15) begin
            // Publish the result from the final step's combinational value so
            // out_valid rises together with the DONE state.
            quotient_reg    <= q_next;
            remainder_reg   <= r_next;
            div_by_zero_reg <= 1'b0;
            out_valid_reg   <= 1'b1;
            state_reg       <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = div_by_zero_reg;

endmodule

// File: doc/seq_div_16by8.md
# seq_div_16by8

Sequential restoring divider: 16-bit unsigned dividend ÷ 8-bit unsigned divisor, producing a 16-bit quotient and 8-bit remainder at one quotient bit per clock. It is the inverse datapath of the 8×8 multiplier in the Sobel pipeline. It normalises 16-bit gradient and product terms back to 8-bit pixel range, and checks multiplier products by round trip. Valid/ready handshakes on both sides; one division in flight.

## Interface
- No parameters; widths fixed at 16/8.
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  dividend/divisor valid
- in_ready  output  1  block can accept an operation
- dividend  input  16  unsigned numerator
- divisor  input  8  unsigned denominator
- out_valid  output  1  result valid, held until taken
- out_ready  input  1  downstream accepts result
- quotient  output  16  unsigned quotient
- remainder  output  8  unsigned remainder
- div_by_zero  output  1  result is from divisor == 0

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - Accept on in_valid & in_ready: latch divisor, load dividend into quotient shift register, clear 9-bit partial remainder R, set iteration counter to 0.
  - If divisor == 0, go to DONE directly. Otherwise go to CALC.
- CALC, one step per cycle:
  - T = {R[7:0], Q[15]}; Q shifts left.
  - If T ≥ {1'b0, divisor}: R = T − divisor, Q[0] = 1. Otherwise R = T, Q[0] = 0.
  - After step 16 (counter 15), go to DONE.
  - R is 9 bits because T can reach 2·divisor−1 ≤ 509. Compare and subtract in 9 bits; R[8] is always 0 after a step.
- DONE:
  - out_valid = 1; quotient = Q; remainder = R[7:0].
  - On out_valid & out_ready, go to IDLE.
- Divide by zero: quotient = 16'hFFFF, remainder = dividend[7:0], div_by_zero = 1. For a nonzero divisor, div_by_zero = 0.
- in_valid outside IDLE is ignored; the operand inputs are not sampled.
- quotient, remainder and div_by_zero are stable while out_valid = 1 and out_ready = 0.
- Between results, outputs hold the last result. Only out_valid qualifies them.

## Timing
- Reset: state IDLE, in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0, counter = 0.
- A reset during CALC or DONE aborts the operation. The result is lost and no out_valid is produced.
- Latency, with the accept edge as cycle 0:
  - Normal divide: out_valid high from cycle 17 (16 CALC cycles, then DONE).
  - Divide by zero: out_valid high from cycle 1.
- in_ready and out_valid are never high together.
- in_ready rises the cycle after the out_valid & out_ready handshake. There is one dead cycle per operation; no accept happens in the same cycle as the output handshake.
- Throughput: one division per 18 cycles at most, with out_ready held high.
- in_ready is a registered state decode. It does not depend combinationally on in_valid or out_ready.

## Test plan
- Round trip: dividend 16'h9AD7 (181·219), divisor 8'hDB -> quotient 16'h00B5, remainder 8'h00, div_by_zero 0, out_valid at cycle 17.
- Nonzero remainder: dividend 16'd1000, divisor 8'd7 -> quotient 16'd142, remainder 8'd6.
- Extremes:
  - 16'hFFFF ÷ 8'h01 -> quotient 16'hFFFF, remainder 0.
  - 16'hFFFF ÷ 8'hFF -> quotient 16'h0101, remainder 0.
  - 16'h00FE ÷ 8'hFF -> quotient 0, remainder 8'hFE.
- Divide by zero: 16'h1234 ÷ 0 -> out_valid at cycle 1, quotient 16'hFFFF, remainder 8'h34, div_by_zero 1. A following 16'd10 ÷ 3 -> quotient 3, remainder 1, div_by_zero 0.
- Backpressure and ignored input:
  - Hold out_ready low for 5 cycles after out_valid: outputs stable, in_ready stays 0.
  - Toggle in_valid with new operands during CALC: result is unaffected.
  - Raise out_ready: in_ready = 1 the next cycle.
- Reset mid-operation: assert rst at cycle 8 of CALC -> next cycle in_ready = 1, out_valid = 0, outputs 0. A following 16'd100 ÷ 9 completes correctly: quotient 11, remainder 1.
